// File: rtl/data_sram_axi_bridge.sv
// Bridge from the data cache's sram-like memory port to AXI4-Lite.
// One transaction in flight; request fields are captured when addr_ok is given.
module data_sram_axi_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  // state | meaning
  // IDLE  | waiting for a request; addr_ok follows data_req
  // AR    | read address offered, arvalid held until arready
  // R     | rready high, waiting for read data
  // WR    | AW and W offered; each dropped after its own handshake
  // B     | bready high, waiting for write response
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_t;

  state_t                state;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  aw_done;
  logic                  w_done;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  unused_resp;

  // Response codes carry no meaning for the cache, so they are dropped.
  assign unused_resp  = ^{rresp, bresp};

  assign data_addr_ok = (state == S_IDLE) & data_req;
  assign araddr       = req_addr;
  assign awaddr       = req_addr;
  assign wdata        = req_wdata;
  assign aw_hs        = awvalid & awready;
  assign w_hs         = wvalid & wready;

  always_comb begin
    wstrb = 4'b1111;
    case (req_size)
      2'd0:    wstrb = 4'b0001 << req_addr[1:0];
      2'd1:    wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      req_size     <= '0;
      req_addr     <= '0;
      req_wdata    <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
      data_data_ok <= 1'b0;
      data_rdata   <= '0;
    end else begin
      data_data_ok <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (data_req) begin
            req_size  <= data_size;
            req_addr  <= data_addr;
            req_wdata <= data_wdata;
            if (data_wr) begin
              state   <= S_WR;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              state   <= S_AR;
              arvalid <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            rready       <= 1'b0;
            data_rdata   <= rdata;
            data_data_ok <= 1'b1;
            state        <= S_IDLE;
          end
        end
        S_WR: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          // Leave as soon as the later of the two handshakes completes.
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            bready <= 1'b1;
            state  <= S_B;
          end
        end
        S_B: begin
          if (bvalid) begin
            bready       <= 1'b0;
            data_data_ok <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
